// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared types for the CHIP-8 instruction fetch stage
package chip8_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  // Widest program address a queued entry can carry.
  localparam int PC_W = 16;

  typedef logic [15:0] instr_t;

  typedef struct packed {
    instr_t          instr;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_HI,
    S_LO,
    S_CAP,
    S_STALL
  } fetch_state_t;

endpackage

// File: rtl/chip8_fetch_fifo.sv
// rtl/chip8_fetch_fifo.sv - two-entry prefetch queue; slot0 is always the head
module chip8_fetch_fifo
  import chip8_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic [1:0]   count;

  assign head  = slot0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (empty) slot0 <= din;
          else       slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; a lone head is simply replaced.
          if (full) begin
            slot0 <= slot1;
            slot1 <= din;
          end else begin
            slot0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/chip8_fetch.sv
// rtl/chip8_fetch.sv - CHIP-8 fetch: byte ROM reads, 16-bit assembly, prefetch queue,
// jump redirect and skip-next handling
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              skip_req
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fpc;
  logic [7:0]        hi_byte;
  logic              drop_pending;

  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              pop_drop;
  logic              push;
  logic              pop;
  fetch_entry_t      din;
  fetch_entry_t      head;

  assign accept   = instr_valid && instr_ready;
  assign pop_drop = drop_pending && !fifo_empty;
  assign pop      = accept || pop_drop;
  assign push     = (state == S_CAP) && !redirect_valid;
  assign din      = '{instr: {hi_byte, mem_rdata}, pc: PC_W'(fpc)};

  assign instr_valid = !fifo_empty && !drop_pending;
  assign instr       = head.instr;
  assign instr_pc    = ADDR_W'(head.pc);

  chip8_fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    case (state)
      S_HI: begin
        mem_req   = 1'b1;
        mem_addr  = fpc;
        state_nxt = S_LO;
      end
      S_LO: begin
        mem_req   = 1'b1;
        mem_addr  = fpc + ADDR_W'(1);
        state_nxt = S_CAP;
      end
      S_CAP:   state_nxt = (fifo_empty || pop) ? S_HI : S_STALL;
      S_STALL: state_nxt = fifo_full ? S_STALL : S_HI;
      default: state_nxt = S_HI;
    endcase
    if (redirect_valid) state_nxt = S_HI;
    // The reset state is S_HI, but the ROM must stay idle until reset releases.
    if (rst) begin
      mem_req  = 1'b0;
      mem_addr = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_HI;
      fpc          <= RESET_PC;
      hi_byte      <= '0;
      drop_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid)     fpc <= redirect_pc;
      else if (state == S_CAP) fpc <= fpc + ADDR_W'(2);
      if (state == S_LO) hi_byte <= mem_rdata;
      if (redirect_valid)          drop_pending <= 1'b0;
      else if (accept && skip_req) drop_pending <= 1'b1;
      else if (pop_drop)           drop_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chip8_fetch.sv
// tb/tb_chip8_fetch.sv - directed bench for chip8_fetch with a stream-level
// expected-PC model checked every cycle plus literal timing expectations
module tb_chip8_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        skip_req = 1'b0;

  logic [7:0]  rom [4096];
  logic [11:0] exp_pc;
  logic [11:0] rec_pc;
  int          errors = 0;
  int          checks = 0;

  chip8_fetch #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .skip_req       (skip_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req) mem_rdata <= rom[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    instr_ready = ready;
    skip_req = 1'b0;
    redirect_valid = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 40) begin
      step(1);
      n++;
    end
    chk(name, instr_valid, 1);
  endtask

  // Stream model: the next instruction the execute stage must see, from jumps and skips only.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_valid", instr_valid, 0);
      chk("rst_req", mem_req, 0);
      exp_pc = 12'h000;
    end else begin
      if (instr_valid) begin
        chk("stream_pc", instr_pc, exp_pc);
        chk("stream_instr", instr, {rom[exp_pc], rom[exp_pc + 12'd1]});
      end
      if (instr_valid && instr_ready) exp_pc = exp_pc + (skip_req ? 12'd4 : 12'd2);
      if (redirect_valid) exp_pc = redirect_pc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       t_req [8];
    logic [11:0] t_addr [8];
    logic       t_val [8];

    for (int i = 0; i < 4096; i++) rom[i] = 8'((i * 13 + 7) ^ (i >> 5));
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h60; rom[3] = 8'hAB;
    rom[12'h2A1] = 8'h6E; rom[12'h2A2] = 8'h5D;
    rom[12'hFFE] = 8'hA2; rom[12'hFFF] = 8'hC3;

    t_req  = '{1, 1, 0, 1, 1, 0, 1, 1};
    t_addr = '{12'h0, 12'h1, 12'h0, 12'h2, 12'h3, 12'h0, 12'h4, 12'h5};
    t_val  = '{0, 0, 0, 1, 0, 0, 1, 0};

    // Reset state
    step(3);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_instr", instr, 0);
    chk("reset_instr_pc", instr_pc, 0);

    // Basic fetch, never back-pressured
    do_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("basic_req", mem_req, t_req[c]);
      if (t_req[c]) chk("basic_addr", mem_addr, t_addr[c]);
      chk("basic_valid", instr_valid, t_val[c]);
      if (c == 3) begin
        chk("basic_instr0", instr, 16'h1234);
        chk("basic_pc0", instr_pc, 12'h000);
      end
      if (c == 6) begin
        chk("basic_instr1", instr, 16'h60AB);
        chk("basic_pc1", instr_pc, 12'h002);
      end
    end

    // Back-pressure: queue fills, fetch stalls, then drains in order
    do_reset(1'b0);
    step(20);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_req", mem_req, 0);
      chk("stall_valid", instr_valid, 1);
      chk("stall_head_pc", instr_pc, 12'h000);
    end
    step(1);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("drain_pc0", instr_pc, 12'h000);
    step(1);
    @(negedge clk);
    chk("drain_valid1", instr_valid, 1);
    chk("drain_pc1", instr_pc, 12'h002);
    begin
      int n = 0;
      step(1);
      while (!mem_req && n < 20) begin
        step(1);
        n++;
      end
      chk("resume_req", mem_req, 1);
      chk("resume_addr", mem_addr, 12'h004);
    end

    // Redirect with an entry queued and the low byte read in flight
    do_reset(1'b0);
    step(4);
    redirect_valid = 1'b1;
    redirect_pc = 12'h2A1;
    @(negedge clk);
    chk("redir_inflight_addr", mem_addr, 12'h003);
    chk("redir_queued", instr_valid, 1);
    step(1);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("redir_n1_valid", instr_valid, 0);
    chk("redir_n1_req", mem_req, 1);
    chk("redir_n1_addr", mem_addr, 12'h2A1);
    for (int k = 2; k <= 4; k++) begin
      step(1);
      @(negedge clk);
      chk("redir_valid_timing", instr_valid, (k == 4) ? 1 : 0);
    end
    chk("redir_target_pc", instr_pc, 12'h2A1);
    chk("redir_target_instr", instr, 16'h6E5D);

    // Skip with the next entry already queued
    do_reset(1'b0);
    step(10);
    instr_ready = 1'b1;
    skip_req = 1'b1;
    step(1);
    skip_req = 1'b0;
    chk("skip_drop_cycle", instr_valid, 0);
    wait_valid("skip_wait");
    chk("skip_next_pc", instr_pc, 12'h004);

    // Skip on the last queued entry: the next fetched instruction is dropped
    rec_pc = instr_pc;
    skip_req = 1'b1;
    step(1);
    skip_req = 1'b0;
    wait_valid("skip_last_wait");
    chk("skip_last_pc", instr_pc, rec_pc + 12'd4);

    // Address wrap, even and odd targets
    redirect_valid = 1'b1;
    redirect_pc = 12'hFFE;
    step(1);
    redirect_valid = 1'b0;
    wait_valid("wrap_wait0");
    chk("wrap_pc0", instr_pc, 12'hFFE);
    chk("wrap_instr0", instr, 16'hA2C3);
    step(1);
    wait_valid("wrap_wait1");
    chk("wrap_pc1", instr_pc, 12'h000);
    chk("wrap_instr1", instr, 16'h1234);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 12'hFFF;
    step(1);
    redirect_valid = 1'b0;
    wait_valid("odd_wait0");
    chk("odd_pc0", instr_pc, 12'hFFF);
    chk("odd_instr0", instr, 16'hC312);
    step(1);
    wait_valid("odd_wait1");
    chk("odd_pc1", instr_pc, 12'h001);
    chk("odd_instr1", instr, 16'h3460);

    // Reset asserted mid-fetch clears everything immediately
    do_reset(1'b0);
    step(4);
    chk("midrst_pre_instr", instr, 16'h1234);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req", mem_req, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_instr", instr, 0);
    chk("midrst_pc", instr_pc, 0);
    step(1);
    rst = 1'b0;
    instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_restart_valid", instr_valid, (c == 3) ? 1 : 0);
    end
    chk("midrst_restart_pc", instr_pc, 12'h000);
    chk("midrst_restart_instr", instr, 16'h1234);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
